mem_wb_pipe: RTL and testbench

Parametrised MEM/WB pipeline stage for the five-stage MIPS core, replacing the fixed-width, always-advancing MEM/WB register. It holds up to two in-flight instructions in a main register plus a skid register, and uses a valid/ready handshake so the write-back side can stall without a combinational ready path back into MEM. It supports a synchronous flush and produces the final write-back result, including load-data extraction.

---
 rtl/mem_wb_pipe.sv | 134 +++++++++++++
 tb/tb_mem_wb_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: main + skid register with valid/ready handshake, flush and load formatting.
// Define MEM_WB_LOAD_ALIGN_EN to enable byte/half lane extraction and sign/zero extension.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FlushM,
  input  logic              ValidM,
  output logic              ReadyM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [LT_W-1:0]   LoadTypeM,
  output logic              ValidW,
  input  logic              ReadyW,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] WriteRegW,
  output logic [DATA_W-1:0] ResultW
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_out;
    logic [REG_AW-1:0] write_reg;
    logic [LT_W-1:0]   load_type;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d;
  entry_t in_entry;
  logic   accept, take;

  assign in_entry = '{reg_write:  RegWriteM,
                      mem_to_reg: MemtoRegM,
                      read_data:  ReadDataM,
                      alu_out:    ALUOutM,
                      write_reg:  WriteRegM,
                      load_type:  LoadTypeM};

  assign accept = ValidM & ReadyM;
  assign take   = ValidW & ReadyW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FlushM) begin
      // Flush drops everything, including an accept offered in the same cycle.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && take) begin
            main_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = StTwo;
          end else if (take) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (take) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  logic [DATA_W-1:0] load_val;

`ifdef MEM_WB_LOAD_ALIGN_EN
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = main_q.read_data[8*main_q.alu_out[1:0] +: 8];
    load_half = main_q.alu_out[1] ? main_q.read_data[31:16] : main_q.read_data[15:0];
    case (main_q.load_type)
      LT_W'(1): load_val = {{(DATA_W-8){load_byte[7]}}, load_byte};
      LT_W'(2): load_val = {{(DATA_W-8){1'b0}}, load_byte};
      LT_W'(3): load_val = {{(DATA_W-16){load_half[15]}}, load_half};
      LT_W'(4): load_val = {{(DATA_W-16){1'b0}}, load_half};
      default:  load_val = main_q.read_data;
    endcase
  end
`else
  logic unused_load_type;

  assign unused_load_type = ^main_q.load_type;
  assign load_val         = main_q.read_data;
`endif

  always_comb begin
    ReadyM    = (state_q != StTwo);
    ValidW    = (state_q != StEmpty);
    RegWriteW = ValidW & main_q.reg_write;
    WriteRegW = main_q.write_reg;
    ResultW   = main_q.mem_to_reg ? load_val : main_q.alu_out;
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (handshake, stall, flush, reset, load formatting).
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        FlushM, ValidM, ReadyM;
  logic        RegWriteM, MemtoRegM;
  logic [31:0] ReadDataM, ALUOutM;
  logic [4:0]  WriteRegM;
  logic [2:0]  LoadTypeM;
  logic        ValidW, ReadyW, RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;

  int checks = 0;
  int errors = 0;

  mem_wb_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .FlushM    (FlushM),
    .ValidM    (ValidM),
    .ReadyM    (ReadyM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .ReadDataM (ReadDataM),
    .ALUOutM   (ALUOutM),
    .WriteRegM (WriteRegM),
    .LoadTypeM (LoadTypeM),
    .ValidW    (ValidW),
    .ReadyW    (ReadyW),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wr, input logic [2:0] lt);
    ValidM    = v;
    RegWriteM = rw;
    MemtoRegM = m2r;
    ReadDataM = rd;
    ALUOutM   = alu;
    WriteRegM = wr;
    LoadTypeM = lt;
  endtask

  logic [31:0] align_addr [6];
  logic [2:0]  align_lt   [6];
  logic [31:0] align_exp  [6];

  initial begin
    align_addr = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h103, 32'h102};
    align_lt   = '{3'd1, 3'd1, 3'd4, 3'd0, 3'd2, 3'd3};
`ifdef MEM_WB_LOAD_ALIGN_EN
    align_exp  = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'h80FF7F01,
                   32'h00000080, 32'hFFFF80FF};
`else
    align_exp  = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                   32'h80FF7F01, 32'h80FF7F01};
`endif

    rst = 1'b1; FlushM = 1'b0; ReadyW = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step(); step();
    rst = 1'b0;
    check("rst_readym", {31'b0, ReadyM}, 32'd1);
    check("rst_validw", {31'b0, ValidW}, 32'd0);
    check("rst_regwrw", {31'b0, RegWriteW}, 32'd0);
    check("rst_wregw", {27'b0, WriteRegW}, 32'd0);
    check("rst_result", ResultW, 32'd0);

    // Basic push with 1-cycle latency.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h1234, 5'd8, 3'd0);
    step();
    check("push_validw", {31'b0, ValidW}, 32'd1);
    check("push_regwrw", {31'b0, RegWriteW}, 32'd1);
    check("push_wregw", {27'b0, WriteRegW}, 32'd8);
    check("push_result", ResultW, 32'h00001234);
    check("push_readym", {31'b0, ReadyM}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step();
    check("drain_validw", {31'b0, ValidW}, 32'd0);

    // Stall: fill both slots, third offer must wait.
    ReadyW = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h11, 5'd1, 3'd0);
    step();
    check("stall1_readym", {31'b0, ReadyM}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h22, 5'd2, 3'd0);
    step();
    check("stall2_readym", {31'b0, ReadyM}, 32'd0);
    check("stall2_wregw", {27'b0, WriteRegW}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h33, 5'd3, 3'd0);
    step();
    check("stall3_readym", {31'b0, ReadyM}, 32'd0);
    check("stall3_result", ResultW, 32'h11);
    ReadyW = 1'b1;
    step();
    check("rel1_wregw", {27'b0, WriteRegW}, 32'd2);
    check("rel1_result", ResultW, 32'h22);
    check("rel1_readym", {31'b0, ReadyM}, 32'd1);
    step();
    check("rel2_wregw", {27'b0, WriteRegW}, 32'd3);
    check("rel2_result", ResultW, 32'h33);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step();
    check("rel3_validw", {31'b0, ValidW}, 32'd0);

    // Load formatting from main register.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h80FF7F01, align_addr[i], 5'd7, align_lt[i]);
      step();
      check($sformatf("align_%0d", i), ResultW, align_exp[i]);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step();

    // Flush in TWO together with an offer.
    ReadyW = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h44, 5'd4, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd5, 3'd0);
    step();
    check("fl_pre_readym", {31'b0, ReadyM}, 32'd0);
    FlushM = 1'b1; ReadyW = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 5'd6, 3'd0);
    step();
    check("fl_validw", {31'b0, ValidW}, 32'd0);
    check("fl_regwrw", {31'b0, RegWriteW}, 32'd0);
    check("fl_readym", {31'b0, ReadyM}, 32'd1);
    FlushM = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step();
    check("fl_post_validw", {31'b0, ValidW}, 32'd0);

    // Reset during a full stall.
    ReadyW = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd11, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h88, 5'd12, 3'd0);
    step();
    check("rs_pre_readym", {31'b0, ReadyM}, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step();
    rst = 1'b0;
    check("rs_readym", {31'b0, ReadyM}, 32'd1);
    check("rs_validw", {31'b0, ValidW}, 32'd0);
    check("rs_wregw", {27'b0, WriteRegW}, 32'd0);
    check("rs_result", ResultW, 32'd0);
    ReadyW = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h99, 5'd9, 3'd0);
    step();
    check("rs_new_validw", {31'b0, ValidW}, 32'd1);
    check("rs_new_wregw", {27'b0, WriteRegW}, 32'd9);
    check("rs_new_result", ResultW, 32'h99);

    // Bubble occupies a slot without writing.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hAA, 5'd10, 3'd0);
    step();
    check("bub_validw", {31'b0, ValidW}, 32'd1);
    check("bub_regwrw", {31'b0, RegWriteW}, 32'd0);
    check("bub_wregw", {27'b0, WriteRegW}, 32'd10);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'd0);
    step();
    check("bub_drain", {31'b0, ValidW}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
